// File: rtl/isp_downscaler.sv
// isp_downscaler: raster pixel stream to GRID x GRID block-average grid.
// Stage 1 accumulates one block row at a time (one accumulator per block
// column). Stage 2 scales the block sum by a reciprocal constant and writes
// the byte into a block RAM. A separate registered read port serves the grid.
module isp_downscaler #(
  parameter int H_FACTOR = 20,
  parameter int V_FACTOR = 15,
  parameter int GRID     = 32,
  parameter int RECIP    = 1748,
  parameter int SHIFT    = 19,
  localparam int AW      = (GRID > 1) ? $clog2(GRID) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [7:0]    in_pixel,
  input  logic [AW-1:0] rd_row,
  input  logic [AW-1:0] rd_col,
  output logic [7:0]    rd_data,
  output logic          frame_done,
  output logic          grid_valid
);

  localparam int HW   = (H_FACTOR > 1) ? $clog2(H_FACTOR) : 1;
  localparam int VW   = (V_FACTOR > 1) ? $clog2(V_FACTOR) : 1;
  localparam int SUMW = $clog2(H_FACTOR * V_FACTOR * 255 + 1);
  localparam int RW   = $clog2(RECIP + 1);
  localparam int PW   = SUMW + RW;
  localparam int MW   = 2 * AW;

  localparam logic [HW-1:0] HMAX = HW'(H_FACTOR - 1);
  localparam logic [VW-1:0] VMAX = VW'(V_FACTOR - 1);
  localparam logic [AW-1:0] GMAX = AW'(GRID - 1);

  // Position counters (pixel within block, block column, line within block, block row)
  logic [HW-1:0] r_hcnt;
  logic [AW-1:0] r_col;
  logic [VW-1:0] r_vcnt;
  logic [AW-1:0] r_row;

  // Effective position of the current pixel (sof forces the origin) and its successor
  logic [HW-1:0] w_hcnt, w_hcnt_nx;
  logic [AW-1:0] w_col, w_col_nx;
  logic [VW-1:0] w_vcnt, w_vcnt_nx;
  logic [AW-1:0] w_row, w_row_nx;

  logic [SUMW-1:0] r_acc [GRID];
  logic [SUMW-1:0] w_sum;
  logic            w_first;
  logic            w_blk_end;

  logic            r_s2_valid;
  logic [SUMW-1:0] r_s2_sum;
  logic [AW-1:0]   r_s2_row;
  logic [AW-1:0]   r_s2_col;

  logic [PW-1:0]   w_prod;
  logic [PW-1:0]   w_quot;
  logic [7:0]      w_avg;
  logic            w_last_blk;

  logic [7:0]      r_mem [1 << MW];
  logic [7:0]      r_rd_data;
  logic            r_frame_done;
  logic            r_grid_valid;

  // Resolve the current pixel position and the raster-order next position
  always_comb begin
    w_hcnt = r_hcnt;
    w_col  = r_col;
    w_vcnt = r_vcnt;
    w_row  = r_row;
    if (in_sof) begin
      w_hcnt = '0;
      w_col  = '0;
      w_vcnt = '0;
      w_row  = '0;
    end
    w_hcnt_nx = w_hcnt + 1'b1;
    w_col_nx  = w_col;
    w_vcnt_nx = w_vcnt;
    w_row_nx  = w_row;
    if (w_hcnt == HMAX) begin
      w_hcnt_nx = '0;
      w_col_nx  = w_col + 1'b1;
      if (w_col == GMAX) begin
        w_col_nx  = '0;
        w_vcnt_nx = w_vcnt + 1'b1;
        if (w_vcnt == VMAX) begin
          w_vcnt_nx = '0;
          w_row_nx  = (w_row == GMAX) ? '0 : w_row + 1'b1;
        end
      end
    end
  end

  assign w_first   = (w_hcnt == '0) && (w_vcnt == '0);
  assign w_blk_end = (w_hcnt == HMAX) && (w_vcnt == VMAX);
  assign w_sum     = w_first ? SUMW'(in_pixel) : r_acc[w_col] + SUMW'(in_pixel);

  // Advance the position counters on every accepted pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt <= '0;
      r_col  <= '0;
      r_vcnt <= '0;
      r_row  <= '0;
    end else if (in_valid) begin
      r_hcnt <= w_hcnt_nx;
      r_col  <= w_col_nx;
      r_vcnt <= w_vcnt_nx;
      r_row  <= w_row_nx;
    end
  end

  // Stage 1: load on the first pixel of a block, accumulate otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < GRID; i++) begin
        r_acc[i] <= '0;
      end
    end else if (in_valid) begin
      r_acc[w_col] <= w_sum;
    end
  end

  // Hand the completed block sum and its address to stage 2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_row   <= '0;
      r_s2_col   <= '0;
    end else begin
      r_s2_valid <= in_valid && w_blk_end;
      if (in_valid && w_blk_end) begin
        r_s2_sum <= w_sum;
        r_s2_row <= w_row;
        r_s2_col <= w_col;
      end
    end
  end

  // Stage 2 arithmetic: multiply by reciprocal, shift, clamp to a byte
  assign w_prod     = PW'(r_s2_sum) * PW'(RECIP);
  assign w_quot     = w_prod >> SHIFT;
  assign w_avg      = (w_quot > PW'(255)) ? 8'hFF : w_quot[7:0];
  assign w_last_blk = (r_s2_row == GMAX) && (r_s2_col == GMAX);

  // Grid RAM write port (contents are deliberately not reset)
  always_ff @(posedge clk) begin
    if (r_s2_valid) begin
      r_mem[{r_s2_row, r_s2_col}] <= w_avg;
    end
  end

  // Frame-complete pulse and sticky grid-valid flag, driven by the last block write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_done <= 1'b0;
      r_grid_valid <= 1'b0;
    end else begin
      r_frame_done <= r_s2_valid && w_last_blk;
      if (r_s2_valid && w_last_blk) begin
        r_grid_valid <= 1'b1;
      end
    end
  end

  // Registered random-access read; a same-cycle write returns the old byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_mem[{rd_row, rd_col}];
    end
  end

  assign rd_data    = r_rd_data;
  assign frame_done = r_frame_done;
  assign grid_valid = r_grid_valid;

endmodule

// File: tb/tb_isp_downscaler.sv
// tb_isp_downscaler: drives whole frames through a reduced-size downscaler
// (5x3 blocks, 8x8 grid) and checks the grid through a read scoreboard.
module tb_isp_downscaler;

  localparam int H     = 5;
  localparam int V     = 3;
  localparam int G     = 8;
  localparam int RECIP = 34953;   // round(2^19 / 15)
  localparam int SHIFT = 19;
  localparam int W     = H * G;
  localparam int HT    = V * G;
  localparam int NPIX  = W * HT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic [2:0] rd_row = 3'd0;
  logic [2:0] rd_col = 3'd0;
  logic [7:0] rd_data;
  logic       frame_done;
  logic       grid_valid;

  isp_downscaler #(
    .H_FACTOR(H), .V_FACTOR(V), .GRID(G), .RECIP(RECIP), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .frame_done(frame_done), .grid_valid(grid_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int fd_cnt  = 0;
  int fd_last = -1;
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt  <= fd_cnt + 1;
      fd_last <= cyc;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int r; int c; int e; } rd_t;
  rd_t sbq[$];

  typedef struct { int pat; int duty; bit sof; } fvec_t;

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  // Pixel value of pattern pat at raster position (x, y)
  function automatic int pix(int pat, int x, int y);
    int r  = y / V;
    int c  = x / H;
    int k  = r * G + c;
    int li = (y % V) * H + (x % H);
    case (pat)
      0: return 128;
      1: return (k == G * G - 1) ? 255 : (k * 37) % 256;
      2: begin
        if (r == 0 && c == 0) return (li == 0) ? 255 : 0;
        else if (r == 0 && c == 1) return 255;
        else if (r == 0 && c == 2) return (li < 8) ? 200 : 100;
        else return (x * 7 + y * 3) % 256;
      end
      3: return 16;
      4: return 64;
      5: return 32;
      6: return 119;
      7: return 200;
      default: return 0;
    endcase
  endfunction

  // Reference block average: plain sum over the block, scaled and clamped
  function automatic int exp_blk(int pat, int r, int c);
    longint s = 0;
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        s += longint'(pix(pat, c * H + xx, r * V + yy));
    s = (s * RECIP) >> SHIFT;
    return (s > 255) ? 255 : int'(s);
  endfunction

  task automatic pop_check(string nm);
    rd_t t;
    t = sbq.pop_front();
    check($sformatf("%s rd(%0d,%0d)", nm, t.r, t.c), int'(rd_data), t.e);
  endtask

  task automatic issue_read(int r, int c, int e);
    rd_t t;
    rd_row = 3'(r);
    rd_col = 3'(c);
    t.r = r; t.c = c; t.e = e;
    sbq.push_back(t);
  endtask

  task automatic read_grid(string nm, int pat);
    for (int r = 0; r < G; r++) begin
      for (int c = 0; c < G; c++) begin
        @(negedge clk);
        if (sbq.size() > 0) pop_check(nm);
        issue_read(r, c, exp_blk(pat, r, c));
      end
    end
    @(negedge clk);
    pop_check(nm);
  endtask

  // Drive npix pixels of a pattern; idle cycles carry junk data and junk sof
  task automatic drive_frame(int pat, int duty, bit sof, int npix, output int last_k);
    last_k = 0;
    for (int p = 0; p < npix; p++) begin
      if (duty < 100) begin
        while ($urandom_range(99) >= duty) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_sof   = 1'($urandom_range(1));
          in_pixel = 8'($urandom_range(255));
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof && (p == 0);
      in_pixel = 8'(pix(pat, p % W, p / W));
      last_k   = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic frame_checks(string nm, int fd0, int last_k);
    repeat (3) @(negedge clk);
    check({nm, " frame_done count"}, fd_cnt - fd0, 1);
    check({nm, " frame_done cycle"}, fd_last, last_k + 2);
    check({nm, " grid_valid"}, int'(grid_valid), 1);
  endtask

  initial begin
    fvec_t tbl[5];
    int k;
    int kb;
    int fd0;

    tbl[0] = '{pat: 0, duty: 100, sof: 1'b1};   // constant 128
    tbl[1] = '{pat: 1, duty: 100, sof: 1'b1};   // block-coded
    tbl[2] = '{pat: 2, duty: 100, sof: 1'b1};   // single-block corner values
    tbl[3] = '{pat: 1, duty: 30,  sof: 1'b1};   // block-coded, gapped input
    tbl[4] = '{pat: 7, duty: 100, sof: 1'b0};   // natural wrap, no sof

    #1 rst = 1'b0;
    #1;
    check("reset rd_data",    int'(rd_data),    0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset grid_valid", int'(grid_valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      fd0 = fd_cnt;
      drive_frame(tbl[i].pat, tbl[i].duty, tbl[i].sof, NPIX, k);
      frame_checks($sformatf("vec%0d", i), fd0, k);
      read_grid($sformatf("vec%0d", i), tbl[i].pat);
    end

    // Resync: partial frame of 0x40 with a read-during-write probe on block (0,0)
    fd0 = fd_cnt;
    rd_row = 3'd0;
    rd_col = 3'd0;
    kb = -100;
    for (int p = 0; p < 10 * W; p++) begin
      @(negedge clk);
      if (cyc == kb + 1) check("rdw before write", int'(rd_data), 200);
      if (cyc == kb + 2) check("rdw same cycle",   int'(rd_data), 200);
      if (cyc == kb + 3) check("rdw after write",  int'(rd_data), 64);
      in_valid = 1'b1;
      in_sof   = (p == 0);
      in_pixel = 8'(pix(4, p % W, p / W));
      if (p == 2 * W + H - 1) kb = cyc;
    end
    drive_frame(3, 100, 1'b1, NPIX, k);
    frame_checks("resync", fd0, k);
    read_grid("resync", 3);

    // Reset right after the block (6,0) end pixel: that write must be dropped
    drive_frame(6, 100, 1'b1, 20 * W + H, k);
    rst = 1'b0;
    #1;
    check("midrst rd_data",    int'(rd_data),    0);
    check("midrst frame_done", int'(frame_done), 0);
    check("midrst grid_valid", int'(grid_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue_read(6, 0, 16);
    @(negedge clk);
    pop_check("midrst dropped");
    issue_read(5, 0, 119);
    @(negedge clk);
    pop_check("midrst kept");
    check("midrst grid_valid after release", int'(grid_valid), 0);

    fd0 = fd_cnt;
    drive_frame(5, 100, 1'b0, NPIX, k);
    frame_checks("postrst", fd0, k);
    read_grid("postrst", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
